float_formula_issuer: RTL and testbench
=======================================

// Module: float_formula_issuer
// PURPOSE
//  Initiator/collector for the pipelined float formula unit (a,b,c -> res/res_negative/err).
//  Accepts argument triples over valid/ready and drives the unit's arg_vld/a/b/c inputs.
//  Collects every completion into a result FIFO and presents it downstream over valid/ready.
//  Uses credit accounting because the unit has no back-pressure. A watchdog retires lost ops.
// PARAMETERS
//  FLEN     8   float width of a, b, c and res
//  DEPTH    4   result FIFO depth and max credits (in flight + buffered); power of 2, >=2
//  TIMEOUT  64  cycles without any completion while in flight before the oldest op is retired
// PORTS
//  clk              in   1     clock, all state on posedge
//  rst_n            in   1     asynchronous, active-low reset
//  up_vld           in   1     argument triple valid
//  up_rdy           out  1     issuer can take a triple
//  up_a/up_b/up_c   in   FLEN  formula arguments
//  fu_arg_vld       out  1     one-cycle issue pulse to the formula unit
//  fu_a/fu_b/fu_c   out  FLEN  registered arguments, stable while fu_arg_vld=1
//  fu_res_vld       in   1     unit result valid
//  fu_res           in   FLEN  unit result
//  fu_res_negative  in   1     unit sign flag
//  fu_err           in   1     unit error (NaN/Inf); the unit may assert it without fu_res_vld
//  fu_busy          in   1     unit busy; no issue while high
//  dn_vld           out  1     result FIFO not empty
//  dn_rdy           in   1     downstream accepts the head entry
//  dn_res           out  FLEN  head result
//  dn_negative      out  1     head sign flag
//  dn_err           out  1     head errored (unit error or timeout)
//  dn_timeout       out  1     head retired by watchdog
//  inflight         out  $clog2(DEPTH)+1  ops issued and not yet completed
//  protocol_err     out  1     sticky: spurious completion or FIFO overflow
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FIFO empty, inflight=0, watchdog=0, FSM=IDLE.
//  Credits: credit_ok = (inflight + fifo_count + issuing) < DEPTH.
//  up_rdy = credit_ok & !fu_busy & (state==IDLE). It is combinational and does not depend on up_vld.
//  FSM IDLE: up_vld&up_rdy -> capture up_a/b/c into fu_a/b/c and go to ISSUE.
//  FSM ISSUE: fu_arg_vld=1 for exactly one cycle (handshake at N -> pulse at N+1).
//    inflight increments at the end of that cycle. Next state is HOLD if fu_busy=1, else IDLE.
//  FSM HOLD: wait until fu_busy=0, then go to IDLE. fu_a/b/c keep their last values outside ISSUE.
//  Completion event (per cycle): fu_res_vld | fu_err. At most one completion counts per cycle.
//    Entry: res = fu_res_vld&!fu_err ? fu_res : 0; negative = fu_res_negative&fu_res_vld&!fu_err.
//    Entry: err = fu_err; timeout = 0. The entry is written to the FIFO on the same edge.
//    inflight decrements on completion. Issue and completion in the same cycle leave it unchanged.
//  Spurious completion (inflight==0): no write, protocol_err<=1. Includes late results after reset.
//  Watchdog counts cycles with inflight>0 and no completion. It clears on completion or when inflight==0.
//    At TIMEOUT it writes {res=0, negative=0, err=1, timeout=1}, decrements inflight and resets to 0.
//  FIFO: show-ahead, dn_* = head entry, dn_vld = !empty. Pop on dn_vld&dn_rdy.
//    Push and pop in the same cycle keep the count unchanged; simultaneous push/pop is legal at full and empty.
//    Push when full without a pop (credit mismatch only): drop the entry, protocol_err<=1.
//  protocol_err clears only on reset. Pointers wrap modulo DEPTH. No combinational path fu_* -> dn_*.
// TESTING
//  1 up triple a=8'h38,b=8'h40,c=8'h3C at cyc0 -> fu_arg_vld=1 cyc1 with same values;
//    then fu_res_vld, fu_res=8'hC4 -> next cyc dn_vld=1, dn_res=8'hC4, dn_negative=1, dn_err=0.
//  2 dn_rdy=0, fu_busy=0, unit returns each result 3 cyc after issue, 6 triples offered
//    -> exactly 4 accepted, up_rdy=0 until dn pop; after 2 pops 2 more accepted, order preserved.
//  3 fu_err=1 for 1 cyc with fu_res_vld=0, inflight=1 -> one entry dn_err=1, dn_res=0, inflight=0.
//  4 TIMEOUT=16, issue one op, no completion -> 16 cyc after issue, entry dn_err=1, dn_timeout=1, inflight=0.
//  5 fu_res_vld pulse with inflight=0 -> dn_vld stays 0, protocol_err=1 until reset.
//  6 fu_busy=1 at handshake; rst_n low with 2 ops in flight and 1 buffered
//    -> pulse is still issued and FSM holds in HOLD while busy; after reset all outputs are 0, up_rdy=1.

Source files
------------

// File: rtl/float_formula_issuer.sv
// Issues argument triples to the pipelined float formula unit and collects its completions.
// The unit cannot stall, so credits (in flight + buffered) bound issue to the result FIFO depth.
module float_formula_issuer #(
    parameter int FLEN    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_vld,
    output logic                       up_rdy,
    input  logic [FLEN-1:0]            up_a,
    input  logic [FLEN-1:0]            up_b,
    input  logic [FLEN-1:0]            up_c,
    output logic                       fu_arg_vld,
    output logic [FLEN-1:0]            fu_a,
    output logic [FLEN-1:0]            fu_b,
    output logic [FLEN-1:0]            fu_c,
    input  logic                       fu_res_vld,
    input  logic [FLEN-1:0]            fu_res,
    input  logic                       fu_res_negative,
    input  logic                       fu_err,
    input  logic                       fu_busy,
    output logic                       dn_vld,
    input  logic                       dn_rdy,
    output logic [FLEN-1:0]            dn_res,
    output logic                       dn_negative,
    output logic                       dn_err,
    output logic                       dn_timeout,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       protocol_err,
    output logic [1:0]                 dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on valid, and valid is held with stable data until it transfers.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FLEN-1:0] res;
        logic            negative;
        logic            err;
        logic            timeout;
    } entry_t;

    state_t            state_q, state_d;
    logic [FLEN-1:0]   fu_a_q, fu_a_d, fu_b_q, fu_b_d, fu_c_q, fu_c_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [WW-1:0]     wd_q, wd_d;
    logic              perr_q, perr_d;

    logic              issuing, credit_ok, up_fire;
    logic [CW:0]       credit_sum;
    logic              comp, have_inflight, comp_ok, spurious;
    logic              wd_count_en, wd_fire;
    logic              push, pop, full, do_write, overflow;
    entry_t            new_entry;
    entry_t            head;

    // Credit check and issue FSM
    always_comb begin
        issuing    = (state_q == S_ISSUE);
        credit_sum = (CW+1)'(inflight_q) + (CW+1)'(count_q) + (CW+1)'(issuing);
        credit_ok  = credit_sum < (CW+1)'(DEPTH);
        up_rdy     = credit_ok & ~fu_busy & (state_q == S_IDLE);
        up_fire    = up_vld & up_rdy;

        state_d = state_q;
        fu_a_d  = fu_a_q;
        fu_b_d  = fu_b_q;
        fu_c_d  = fu_c_q;
        case (state_q)
            S_IDLE: begin
                if (up_fire) begin
                    fu_a_d  = up_a;
                    fu_b_d  = up_b;
                    fu_c_d  = up_c;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = fu_busy ? S_HOLD : S_IDLE;
            S_HOLD:  if (!fu_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Completions, watchdog and result FIFO
    always_comb begin
        comp          = fu_res_vld | fu_err;
        have_inflight = (inflight_q != '0);
        comp_ok       = comp & have_inflight;
        spurious      = comp & ~have_inflight;

        wd_count_en = have_inflight & ~comp;
        wd_fire     = wd_count_en && (wd_q == WW'(TIMEOUT - 1));
        wd_d        = (!wd_count_en || wd_fire) ? '0 : wd_q + 1'b1;

        if (wd_fire) begin
            new_entry = '{res: '0, negative: 1'b0, err: 1'b1, timeout: 1'b1};
        end else begin
            new_entry.res      = (fu_res_vld & ~fu_err) ? fu_res : '0;
            new_entry.negative = fu_res_negative & fu_res_vld & ~fu_err;
            new_entry.err      = fu_err;
            new_entry.timeout  = 1'b0;
        end

        push     = comp_ok | wd_fire;
        pop      = dn_vld & dn_rdy;
        full     = (count_q == CW'(DEPTH));
        do_write = push & (~full | pop);
        overflow = push & full & ~pop;

        mem_d = mem_q;
        if (do_write) mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d = wr_ptr_q + AW'(do_write);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(do_write) - CW'(pop);

        inflight_d = inflight_q + CW'(issuing) - CW'(push);
        perr_d     = perr_q | spurious | overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            fu_c_q     <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wd_q       <= '0;
            perr_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            fu_c_q     <= fu_c_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wd_q       <= wd_d;
            perr_q     <= perr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Downstream is driven purely from registered FIFO state
    always_comb begin
        head         = mem_q[rd_ptr_q];
        dn_vld       = (count_q != '0);
        dn_res       = head.res;
        dn_negative  = head.negative;
        dn_err       = head.err;
        dn_timeout   = head.timeout;
        fu_arg_vld   = (state_q == S_ISSUE);
        fu_a         = fu_a_q;
        fu_b         = fu_b_q;
        fu_c         = fu_c_q;
        inflight     = inflight_q;
        protocol_err = perr_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_float_formula_issuer.sv
// Directed bench for float_formula_issuer: table-driven single ops plus multi-cycle
// sequences for credit back-pressure, watchdog retirement, spurious completion and reset.
module tb_float_formula_issuer;

    localparam int FLEN    = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_HOLD = 2'd2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            up_vld, up_rdy;
    logic [FLEN-1:0] up_a, up_b, up_c;
    logic            fu_arg_vld;
    logic [FLEN-1:0] fu_a, fu_b, fu_c;
    logic            fu_res_vld;
    logic [FLEN-1:0] fu_res;
    logic            fu_res_negative, fu_err, fu_busy;
    logic            dn_vld, dn_rdy;
    logic [FLEN-1:0] dn_res;
    logic            dn_negative, dn_err, dn_timeout;
    logic [CW-1:0]   inflight;
    logic            protocol_err;
    logic [1:0]      dbg_state;

    float_formula_issuer #(.FLEN(FLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_vld(up_vld), .up_rdy(up_rdy), .up_a(up_a), .up_b(up_b), .up_c(up_c),
        .fu_arg_vld(fu_arg_vld), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
        .fu_res_vld(fu_res_vld), .fu_res(fu_res), .fu_res_negative(fu_res_negative),
        .fu_err(fu_err), .fu_busy(fu_busy),
        .dn_vld(dn_vld), .dn_rdy(dn_rdy), .dn_res(dn_res), .dn_negative(dn_negative),
        .dn_err(dn_err), .dn_timeout(dn_timeout),
        .inflight(inflight), .protocol_err(protocol_err), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a, b, c, res;
        logic       neg, vld, err;
        logic [7:0] e_res;
        logic       e_neg, e_err;
    } vec_t;
    vec_t vecs[5];

    typedef struct {
        int         due;
        logic [7:0] d;
    } pend_t;
    pend_t      pend_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ta[6], tb_[6], tc[6];
    int         k, accepted, cyc, pops_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a triple, wait (bounded) for up_rdy, complete the handshake.
    // Returns one time unit into the cycle after the handshake edge.
    task automatic do_handshake(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int n = 0;
        up_vld = 1'b1;
        up_a = a;
        up_b = b;
        up_c = c;
        #1;
        while (!up_rdy && n < 50) begin
            step();
            n++;
        end
        chk("hs_up_rdy", up_rdy, 1);
        step();
        up_vld = 1'b0;
    endtask

    // Credit test: models a unit answering 3 cycles after each issue pulse, offers
    // triples k..5 and pops up to pops_left results, checking order on each pop.
    task automatic run_phase(input int ncyc);
        pend_t p;
        logic [7:0] e;
        for (int i = 0; i < ncyc; i++) begin
            step();
            cyc++;
            fu_res_vld = 1'b0;
            fu_res = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                p = pend_q.pop_front();
                fu_res_vld = 1'b1;
                fu_res = p.d;
            end
            if (fu_arg_vld) begin
                p.due = cyc + 3;
                p.d = fu_a ^ fu_b ^ fu_c;
                pend_q.push_back(p);
            end
            up_vld = (k < 6);
            if (k < 6) begin
                up_a = ta[k];
                up_b = tb_[k];
                up_c = tc[k];
            end
            dn_rdy = (pops_left > 0);
            #1;
            if (dn_vld && dn_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("t2_unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("t2_order_res", dn_res, e);
                    chk("t2_order_err", dn_err, 0);
                end
                pops_left--;
            end
            if (up_vld && up_rdy) begin
                exp_q.push_back(ta[k] ^ tb_[k] ^ tc[k]);
                k++;
                accepted++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{a: 8'h38, b: 8'h40, c: 8'h3C, res: 8'hC4, neg: 1, vld: 1, err: 0, e_res: 8'hC4, e_neg: 1, e_err: 0};
        vecs[1] = '{a: 8'h11, b: 8'h22, c: 8'h33, res: 8'h7A, neg: 0, vld: 1, err: 0, e_res: 8'h7A, e_neg: 0, e_err: 0};
        vecs[2] = '{a: 8'h01, b: 8'h02, c: 8'h03, res: 8'hFF, neg: 1, vld: 0, err: 1, e_res: 8'h00, e_neg: 0, e_err: 1};
        vecs[3] = '{a: 8'hA0, b: 8'hB0, c: 8'hC0, res: 8'h55, neg: 1, vld: 1, err: 1, e_res: 8'h00, e_neg: 0, e_err: 1};
        vecs[4] = '{a: 8'hFF, b: 8'h00, c: 8'h7F, res: 8'h80, neg: 0, vld: 1, err: 0, e_res: 8'h80, e_neg: 0, e_err: 0};

        rst_n = 1'b0;
        up_vld = 0; up_a = 0; up_b = 0; up_c = 0;
        fu_res_vld = 0; fu_res = 0; fu_res_negative = 0; fu_err = 0; fu_busy = 0;
        dn_rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dn_vld", dn_vld, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_fu_arg_vld", fu_arg_vld, 0);
        chk("rst_fu_a", fu_a, 0);
        chk("rst_dn_res", dn_res, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        step();
        chk("rst_up_rdy", up_rdy, 1);

        // Single ops: issue, complete with the table's flags, check the FIFO entry, pop
        for (int i = 0; i < 5; i++) begin
            do_handshake(vecs[i].a, vecs[i].b, vecs[i].c);
            chk("vec_arg_vld", fu_arg_vld, 1);
            chk("vec_fu_a", fu_a, vecs[i].a);
            chk("vec_fu_b", fu_b, vecs[i].b);
            chk("vec_fu_c", fu_c, vecs[i].c);
            step();
            chk("vec_arg_vld_off", fu_arg_vld, 0);
            chk("vec_inflight_1", inflight, 1);
            fu_res_vld = vecs[i].vld;
            fu_err = vecs[i].err;
            fu_res = vecs[i].res;
            fu_res_negative = vecs[i].neg;
            step();
            fu_res_vld = 0; fu_err = 0; fu_res = 0; fu_res_negative = 0;
            chk("vec_dn_vld", dn_vld, 1);
            chk("vec_dn_res", dn_res, vecs[i].e_res);
            chk("vec_dn_negative", dn_negative, vecs[i].e_neg);
            chk("vec_dn_err", dn_err, vecs[i].e_err);
            chk("vec_dn_timeout", dn_timeout, 0);
            chk("vec_inflight_0", inflight, 0);
            dn_rdy = 1;
            step();
            dn_rdy = 0;
            chk("vec_dn_empty", dn_vld, 0);
        end

        // Credit back-pressure with dn_rdy=0
        for (int i = 0; i < 6; i++) begin
            ta[i] = 8'(8'h10 * (i + 1));
            tb_[i] = 8'(i + 3);
            tc[i] = 8'(8'hA5 + i);
        end
        k = 0; accepted = 0; cyc = 0; pops_left = 0;
        run_phase(30);
        chk("t2_accepted_4", accepted, 4);
        chk("t2_up_rdy_blocked", up_rdy, 0);
        chk("t2_inflight_0", inflight, 0);
        chk("t2_dn_vld", dn_vld, 1);
        pops_left = 2;
        run_phase(30);
        chk("t2_accepted_6", accepted, 6);
        chk("t2_pops_done", pops_left, 0);
        chk("t2_up_rdy_blocked2", up_rdy, 0);
        pops_left = 4;
        run_phase(20);
        chk("t2_exp_drained", exp_q.size(), 0);
        chk("t2_dn_empty", dn_vld, 0);
        up_vld = 0; dn_rdy = 0; fu_res_vld = 0; fu_res = 0;
        step();

        // Watchdog retirement
        do_handshake(8'h11, 8'h22, 8'h33);
        repeat (TIMEOUT) step();
        chk("wd_not_yet", dn_vld, 0);
        chk("wd_inflight_1", inflight, 1);
        step();
        chk("wd_dn_vld", dn_vld, 1);
        chk("wd_dn_err", dn_err, 1);
        chk("wd_dn_timeout", dn_timeout, 1);
        chk("wd_dn_res", dn_res, 0);
        chk("wd_dn_negative", dn_negative, 0);
        chk("wd_inflight_0", inflight, 0);
        chk("wd_no_perr", protocol_err, 0);
        dn_rdy = 1;
        step();
        dn_rdy = 0;

        // Spurious completion with nothing in flight
        fu_res_vld = 1; fu_res = 8'h5A;
        step();
        fu_res_vld = 0; fu_res = 0;
        chk("sp_dn_vld", dn_vld, 0);
        chk("sp_perr", protocol_err, 1);
        chk("sp_inflight", inflight, 0);
        repeat (3) step();
        chk("sp_perr_sticky", protocol_err, 1);

        // Busy during issue -> HOLD, then reset with 2 in flight and 1 buffered
        do_handshake(8'h21, 8'h43, 8'h65);
        fu_busy = 1;
        #1;
        chk("hold_pulse", fu_arg_vld, 1);
        chk("hold_state_issue", dbg_state, ST_ISSUE);
        chk("hold_up_rdy", up_rdy, 0);
        step();
        chk("hold_state", dbg_state, ST_HOLD);
        chk("hold_pulse_off", fu_arg_vld, 0);
        chk("hold_inflight", inflight, 1);
        step();
        chk("hold_state_2", dbg_state, ST_HOLD);
        fu_busy = 0;
        step();
        chk("hold_to_idle", dbg_state, ST_IDLE);
        fu_res_vld = 1; fu_res = 8'h42;
        step();
        fu_res_vld = 0; fu_res = 0;
        chk("pre_rst_buffered", dn_vld, 1);
        do_handshake(8'h01, 8'h01, 8'h01);
        step();
        do_handshake(8'h02, 8'h02, 8'h02);
        step();
        chk("pre_rst_inflight_2", inflight, 2);
        #2;
        rst_n = 0;
        #1;
        chk("ar_fu_arg_vld", fu_arg_vld, 0);
        chk("ar_fu_a", fu_a, 0);
        chk("ar_fu_b", fu_b, 0);
        chk("ar_fu_c", fu_c, 0);
        chk("ar_dn_vld", dn_vld, 0);
        chk("ar_dn_res", dn_res, 0);
        chk("ar_dn_negative", dn_negative, 0);
        chk("ar_dn_err", dn_err, 0);
        chk("ar_dn_timeout", dn_timeout, 0);
        chk("ar_inflight", inflight, 0);
        chk("ar_protocol_err", protocol_err, 0);
        chk("ar_state", dbg_state, ST_IDLE);
        step();
        rst_n = 1;
        step();
        chk("post_rst_up_rdy", up_rdy, 1);
        chk("post_rst_dn_vld", dn_vld, 0);
        fu_res_vld = 1; fu_res = 8'h33;
        step();
        fu_res_vld = 0; fu_res = 0;
        chk("late_res_dn_vld", dn_vld, 0);
        chk("late_res_perr", protocol_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
